ahb_req_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer in front of the ahb_master command interface.

---
 rtl/ahb_req_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_ahb_req_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: round-robin arbiter that sequences one single-beat command at a
// time into the ahb_master, returns completion data/status, and aborts stuck transfers.
module ahb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_dina,
  input  logic [NREQ*32-1:0] req_dinb,
  input  logic [NREQ*2-1:0]  req_sel,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mst_enable,
  output logic               mst_wr,
  output logic [31:0]        mst_addr,
  output logic [31:0]        mst_dina,
  output logic [31:0]        mst_dinb,
  output logic [1:0]         mst_sel,
  input  logic               hreadyout,
  input  logic               hresp,
  input  logic [31:0]        hrdata
);

  // state  | meaning
  // S_IDLE | no transfer, outputs 0, arbitrate on req
  // S_ADDR | command presented to the master for one cycle
  // S_WAIT | waiting for hreadyout, watchdog running
  // S_RESP | one-cycle ack with rsp_rdata/rsp_err to the winner
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;

  localparam int PTR_W    = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMR_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [PTR_W:0] NREQ_EXT = (PTR_W+1)'(NREQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NREQ-1:0]    req_rot;
  logic               found;
  logic [PTR_W-1:0]   rot_off;
  logic [PTR_W:0]     win_sum;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     ptr_sum;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               timeout_hit;

  logic               cmd_wr;
  logic [31:0]        cmd_addr;
  logic [31:0]        cmd_dina;
  logic [31:0]        cmd_dinb;
  logic [1:0]         cmd_sel;

  logic [NREQ-1:0]    gnt_d;
  logic [NREQ-1:0]    ack_d;
  logic [31:0]        rsp_rdata_d;
  logic               rsp_err_d;
  logic               mst_enable_d;
  logic               mst_wr_d;
  logic [31:0]        mst_addr_d;
  logic [31:0]        mst_dina_d;
  logic [31:0]        mst_dinb_d;
  logic [1:0]         mst_sel_d;

  // Rotate req so bit 0 is the current priority holder, then take the first set bit.
  always_comb begin
    req_rot = NREQ'({req, req} >> ptr_q);
    found   = 1'b0;
    rot_off = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        rot_off = PTR_W'(k);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, rot_off};
    if (win_sum >= NREQ_EXT) begin
      win_sum = win_sum - NREQ_EXT;
    end
    win_idx = win_sum[PTR_W-1:0];
  end

  always_comb begin
    cmd_wr   = 1'b0;
    cmd_addr = '0;
    cmd_dina = '0;
    cmd_dinb = '0;
    cmd_sel  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        cmd_wr   = req_wr[k];
        cmd_addr = req_addr[32*k +: 32];
        cmd_dina = req_dina[32*k +: 32];
        cmd_dinb = req_dinb[32*k +: 32];
        cmd_sel  = req_sel[2*k +: 2];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, win_q} + (PTR_W+1)'(1);
    ptr_nxt = (ptr_sum >= NREQ_EXT) ? '0 : ptr_sum[PTR_W-1:0];
  end

  // Down-counter loaded in ADDR; reaching zero in WAIT marks the last allowed cycle.
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == '0);

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (found) state_d = S_ADDR;
      S_ADDR: state_d = S_WAIT;
      S_WAIT: if (hreadyout || timeout_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d        = gnt;
    ack_d        = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    mst_enable_d = mst_enable;
    mst_wr_d     = mst_wr;
    mst_addr_d   = mst_addr;
    mst_dina_d   = mst_dina;
    mst_dinb_d   = mst_dinb;
    mst_sel_d    = mst_sel;
    win_d        = win_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        gnt_d        = '0;
        mst_enable_d = 1'b0;
        mst_wr_d     = 1'b0;
        mst_addr_d   = '0;
        mst_dina_d   = '0;
        mst_dinb_d   = '0;
        mst_sel_d    = '0;
        if (found) begin
          win_d        = win_idx;
          gnt_d        = NREQ'(1) << win_idx;
          mst_enable_d = 1'b1;
          mst_wr_d     = cmd_wr;
          mst_addr_d   = cmd_addr;
          mst_dina_d   = cmd_dina;
          mst_dinb_d   = cmd_dinb;
          mst_sel_d    = cmd_sel;
        end
      end
      S_ADDR: begin
        timer_d = TMR_W'(TMR_LOAD);
      end
      S_WAIT: begin
        // A completion arriving in the watchdog's last cycle takes precedence.
        if (hreadyout || timeout_hit) begin
          ack_d        = gnt;
          gnt_d        = '0;
          rsp_rdata_d  = (hreadyout && !mst_wr) ? hrdata : '0;
          rsp_err_d    = hreadyout ? hresp : 1'b1;
          mst_enable_d = 1'b0;
          mst_wr_d     = 1'b0;
          mst_addr_d   = '0;
          mst_dina_d   = '0;
          mst_dinb_d   = '0;
          mst_sel_d    = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_RESP: begin
        ptr_d = ptr_nxt;
      end
      default: begin
        gnt_d        = '0;
        mst_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      ptr_q      <= '0;
      win_q      <= '0;
      timer_q    <= '0;
      gnt        <= '0;
      ack        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mst_enable <= 1'b0;
      mst_wr     <= 1'b0;
      mst_addr   <= '0;
      mst_dina   <= '0;
      mst_dinb   <= '0;
      mst_sel    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      timer_q    <= timer_d;
      gnt        <= gnt_d;
      ack        <= ack_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      mst_enable <= mst_enable_d;
      mst_wr     <= mst_wr_d;
      mst_addr   <= mst_addr_d;
      mst_dina   <= mst_dina_d;
      mst_dinb   <= mst_dinb_d;
      mst_sel    <= mst_sel_d;
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Bench for ahb_req_arbiter: scenario tasks with a queue of expected responses
// popped and compared whenever an ack pulse appears.
module tb_ahb_req_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic               hclk;
  logic               hresetn;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_dina;
  logic [NREQ*32-1:0] req_dinb;
  logic [NREQ*2-1:0]  req_sel;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               mst_enable;
  logic               mst_wr;
  logic [31:0]        mst_addr;
  logic [31:0]        mst_dina;
  logic [31:0]        mst_dinb;
  logic [1:0]         mst_sel;
  logic               hreadyout;
  logic               hresp;
  logic [31:0]        hrdata;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  ahb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .req        (req),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_dina   (req_dina),
    .req_dinb   (req_dinb),
    .req_sel    (req_sel),
    .gnt        (gnt),
    .ack        (ack),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mst_enable (mst_enable),
    .mst_wr     (mst_wr),
    .mst_addr   (mst_addr),
    .mst_dina   (mst_dina),
    .mst_dinb   (mst_dinb),
    .mst_sel    (mst_sel),
    .hreadyout  (hreadyout),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic set_cmd(input int r, input logic wr, input logic [31:0] addr,
                         input logic [31:0] dina, input logic [31:0] dinb, input logic [1:0] sel);
    req_wr[r]           = wr;
    req_addr[r*32 +: 32] = addr;
    req_dina[r*32 +: 32] = dina;
    req_dinb[r*32 +: 32] = dinb;
    req_sel[r*2 +: 2]    = sel;
  endtask

  task automatic push_exp(input int idx, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.idx   = idx;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Waits (bounded) for an ack pulse; reports latency, enable cycles, last grant, invariant breaks.
  task automatic wait_ack(input int limit, output logic [NREQ-1:0] a, output int cyc,
                          output int en_cnt, output logic [NREQ-1:0] g_seen, output bit viol);
    a = '0; cyc = 0; en_cnt = 0; g_seen = '0; viol = 1'b0;
    while (cyc < limit) begin
      @(negedge hclk);
      cyc++;
      if (mst_enable) en_cnt++;
      if (gnt != '0) g_seen = gnt;
      if ((gnt != '0 && ack != '0) || !$onehot0(gnt) || !$onehot0(ack)) viol = 1'b1;
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    hresetn   = 1'b0;
    req       = '0;
    hreadyout = 1'b0;
    hresp     = 1'b0;
    hrdata    = '0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (gnt !== '0 || ack !== '0 || mst_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: gnt=%b ack=%b en=%b expected all 0", gnt, ack, mst_enable);
    end
    checks++;
    if (mst_addr !== '0 || mst_wr !== 1'b0 || mst_dina !== '0 || mst_dinb !== '0 || mst_sel !== '0) begin
      failures++;
      $display("FAIL reset_cmd: addr=%h wr=%b dina=%h dinb=%h sel=%b expected all 0",
               mst_addr, mst_wr, mst_dina, mst_dinb, mst_sel);
    end
    checks++;
    if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: rdata=%h err=%b expected 0 0", rsp_rdata, rsp_err);
    end
    @(negedge hclk);
    checks++;
    if (gnt !== '0 || mst_enable !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: gnt=%b en=%b expected 0 0", gnt, mst_enable);
    end
  endtask

  task automatic test_single_write();
    logic [NREQ-1:0] a, g;
    int cyc, en;
    bit viol;
    exp_t e;
    set_cmd(0, 1'b1, 32'd9, 32'd1, 32'd2, 2'b01);
    hreadyout = 1'b1; hresp = 1'b0; hrdata = 32'h5555_5555;
    push_exp(0, 32'd0, 1'b0);
    req = 4'b0001;
    @(negedge hclk);
    checks++;
    if (gnt !== 4'b0001 || mst_enable !== 1'b1 || mst_addr !== 32'd9 || mst_wr !== 1'b1 ||
        mst_sel !== 2'b01 || mst_dina !== 32'd1 || mst_dinb !== 32'd2) begin
      failures++;
      $display("FAIL write_cmd: gnt=%b en=%b addr=%h wr=%b sel=%b dina=%h dinb=%h expected 0001 1 9 1 01 1 2",
               gnt, mst_enable, mst_addr, mst_wr, mst_sel, mst_dina, mst_dinb);
    end
    wait_ack(10, a, cyc, en, g, viol);
    e = sb.pop_front();
    checks++;
    if (a !== (NREQ'(1) << e.idx)) begin
      failures++;
      $display("FAIL write_ack: got %b expected %b", a, NREQ'(1) << e.idx);
    end
    checks++;
    if (cyc + 1 != 3 || en + 1 != 2) begin
      failures++;
      $display("FAIL write_timing: ack_edge=%0d en_cycles=%0d expected 3 2", cyc + 1, en + 1);
    end
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      failures++;
      $display("FAIL write_rsp: rdata=%h err=%b expected %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    req = '0;
    @(negedge hclk);
    checks++;
    if (ack !== '0 || gnt !== '0 || mst_enable !== 1'b0 || viol) begin
      failures++;
      $display("FAIL write_after: ack=%b gnt=%b en=%b viol=%b expected 0 0 0 0", ack, gnt, mst_enable, viol);
    end
  endtask

  task automatic test_single_read();
    logic [NREQ-1:0] a, g;
    int cyc, en;
    bit viol;
    exp_t e;
    set_cmd(2, 1'b0, 32'd9, 32'h0, 32'h0, 2'b10);
    hreadyout = 1'b1; hresp = 1'b0; hrdata = 32'hA5A5_A5A5;
    push_exp(2, 32'hA5A5_A5A5, 1'b0);
    req = 4'b0100;
    @(negedge hclk);
    checks++;
    if (gnt !== 4'b0100 || mst_addr !== 32'd9 || mst_sel !== 2'b10 || mst_wr !== 1'b0) begin
      failures++;
      $display("FAIL read_cmd: gnt=%b addr=%h sel=%b wr=%b expected 0100 9 10 0", gnt, mst_addr, mst_sel, mst_wr);
    end
    // Requester withdraws and scribbles its command after grant; transfer must be unaffected.
    req = '0;
    set_cmd(2, 1'b1, 32'hFFFF_0000, 32'h1, 32'h1, 2'b01);
    @(negedge hclk);
    checks++;
    if (mst_addr !== 32'd9 || mst_wr !== 1'b0 || mst_sel !== 2'b10 || gnt !== 4'b0100) begin
      failures++;
      $display("FAIL read_latched: addr=%h wr=%b sel=%b gnt=%b expected 9 0 10 0100", mst_addr, mst_wr, mst_sel, gnt);
    end
    wait_ack(10, a, cyc, en, g, viol);
    e = sb.pop_front();
    checks++;
    if (a !== (NREQ'(1) << e.idx) || cyc != 1) begin
      failures++;
      $display("FAIL read_ack: got %b after %0d expected %b after 1", a, cyc, NREQ'(1) << e.idx);
    end
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err || viol) begin
      failures++;
      $display("FAIL read_rsp: rdata=%h err=%b viol=%b expected %h %b 0", rsp_rdata, rsp_err, viol, e.rdata, e.err);
    end
    @(negedge hclk);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] a, g;
    int cyc, en;
    bit viol, any_viol;
    exp_t e;
    apply_reset();
    any_viol = 1'b0;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 32'(256 + i), 32'(i), 32'(i), 2'(i));
    hreadyout = 1'b1; hresp = 1'b0; hrdata = 32'hFFFF_FFFF;
    for (int i = 0; i < NREQ; i++) push_exp(i, 32'd0, 1'b0);
    req = '1;
    for (int i = 0; i < NREQ; i++) begin
      wait_ack(20, a, cyc, en, g, viol);
      any_viol |= viol;
      e = sb.pop_front();
      checks++;
      if (a !== (NREQ'(1) << e.idx) || g !== (NREQ'(1) << e.idx)) begin
        failures++;
        $display("FAIL rr_drop_order[%0d]: ack=%b gnt=%b expected %b", i, a, g, NREQ'(1) << e.idx);
      end
      checks++;
      if (cyc != ((i == 0) ? 3 : 4)) begin
        failures++;
        $display("FAIL rr_drop_spacing[%0d]: got %0d expected %0d", i, cyc, (i == 0) ? 3 : 4);
      end
      req = req & ~a;
    end
    for (int i = 0; i <= NREQ; i++) push_exp(i % NREQ, 32'd0, 1'b0);
    req = '1;
    for (int i = 0; i <= NREQ; i++) begin
      wait_ack(20, a, cyc, en, g, viol);
      any_viol |= viol;
      e = sb.pop_front();
      checks++;
      if (a !== (NREQ'(1) << e.idx) || cyc != 4) begin
        failures++;
        $display("FAIL rr_held[%0d]: ack=%b after %0d expected %b after 4", i, a, cyc, NREQ'(1) << e.idx);
      end
    end
    req = '0;
    checks++;
    if (any_viol) begin
      failures++;
      $display("FAIL rr_onehot: got violation expected none");
    end
    @(negedge hclk);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] a, g;
    int cyc, en;
    bit viol;
    exp_t e;
    set_cmd(1, 1'b0, 32'h40, 32'h0, 32'h0, 2'b11);
    hreadyout = 1'b0; hresp = 1'b0; hrdata = 32'hDEAD_BEEF;
    push_exp(1, 32'd0, 1'b1);
    req = 4'b0010;
    wait_ack(60, a, cyc, en, g, viol);
    e = sb.pop_front();
    req = '0;
    checks++;
    if (a !== (NREQ'(1) << e.idx)) begin
      failures++;
      $display("FAIL timeout_ack: got %b expected %b", a, NREQ'(1) << e.idx);
    end
    checks++;
    if (cyc != TIMEOUT + 2 || en != TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_len: ack_edge=%0d en_cycles=%0d expected %0d %0d", cyc, en, TIMEOUT + 2, TIMEOUT + 1);
    end
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err || viol) begin
      failures++;
      $display("FAIL timeout_rsp: rdata=%h err=%b viol=%b expected %h %b 0", rsp_rdata, rsp_err, viol, e.rdata, e.err);
    end
    @(negedge hclk);
  endtask

  task automatic test_error_collision();
    logic [NREQ-1:0] a, g;
    int cyc, en;
    bit viol;
    exp_t e;
    set_cmd(2, 1'b0, 32'h44, 32'h0, 32'h0, 2'b01);
    hreadyout = 1'b1; hresp = 1'b1; hrdata = 32'h1234_5678;
    push_exp(2, 32'h1234_5678, 1'b1);
    req = 4'b0100;
    wait_ack(10, a, cyc, en, g, viol);
    e = sb.pop_front();
    req = '0;
    checks++;
    if (a !== (NREQ'(1) << e.idx) || rsp_err !== e.err || rsp_rdata !== e.rdata || cyc != 3) begin
      failures++;
      $display("FAIL slave_err: ack=%b err=%b rdata=%h edge=%0d expected %b %b %h 3",
               a, rsp_err, rsp_rdata, cyc, NREQ'(1) << e.idx, e.err, e.rdata);
    end
    @(negedge hclk);
    set_cmd(0, 1'b0, 32'h80, 32'h0, 32'h0, 2'b00);
    hreadyout = 1'b0; hresp = 1'b0; hrdata = 32'h0BAD_F00D;
    push_exp(0, 32'h0BAD_F00D, 1'b0);
    req = 4'b0001;
    repeat (TIMEOUT + 1) @(negedge hclk);
    checks++;
    if (ack !== '0 || mst_enable !== 1'b1) begin
      failures++;
      $display("FAIL collide_pre: ack=%b en=%b expected 0 1", ack, mst_enable);
    end
    hreadyout = 1'b1;
    wait_ack(5, a, cyc, en, g, viol);
    e = sb.pop_front();
    req = '0;
    checks++;
    if (a !== (NREQ'(1) << e.idx) || cyc != 1) begin
      failures++;
      $display("FAIL collide_ack: got %b after %0d expected %b after 1", a, cyc, NREQ'(1) << e.idx);
    end
    checks++;
    if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL collide_rsp: err=%b rdata=%h expected %b %h", rsp_err, rsp_rdata, e.err, e.rdata);
    end
    @(negedge hclk);
  endtask

  task automatic test_reset_in_wait();
    logic [NREQ-1:0] a, g;
    int cyc, en, stray;
    bit viol;
    exp_t e;
    set_cmd(1, 1'b1, 32'h10, 32'h3, 32'h4, 2'b10);
    hreadyout = 1'b1; hresp = 1'b0;
    push_exp(1, 32'd0, 1'b0);
    req = 4'b0010;
    wait_ack(10, a, cyc, en, g, viol);
    e = sb.pop_front();
    req = '0;
    checks++;
    if (a !== (NREQ'(1) << e.idx)) begin
      failures++;
      $display("FAIL rst_pre_ack: got %b expected %b", a, NREQ'(1) << e.idx);
    end
    @(negedge hclk);
    set_cmd(3, 1'b1, 32'h30, 32'h5, 32'h6, 2'b11);
    hreadyout = 1'b0;
    req = 4'b1000;
    repeat (3) @(negedge hclk);
    checks++;
    if (gnt !== 4'b1000 || mst_enable !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_wait: gnt=%b en=%b expected 1000 1", gnt, mst_enable);
    end
    hresetn = 1'b0;
    req = '0;
    @(negedge hclk);
    checks++;
    if (gnt !== '0 || ack !== '0 || mst_enable !== 1'b0 || mst_addr !== '0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_outputs: gnt=%b ack=%b en=%b addr=%h err=%b expected all 0",
               gnt, ack, mst_enable, mst_addr, rsp_err);
    end
    hresetn = 1'b1;
    hreadyout = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge hclk);
      if (ack != '0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rst_no_ack: got %0d acks expected 0", stray);
    end
    set_cmd(0, 1'b1, 32'h20, 32'h7, 32'h8, 2'b00);
    push_exp(0, 32'd0, 1'b0);
    push_exp(3, 32'd0, 1'b0);
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      wait_ack(10, a, cyc, en, g, viol);
      e = sb.pop_front();
      checks++;
      if (a !== (NREQ'(1) << e.idx)) begin
        failures++;
        $display("FAIL rst_ptr[%0d]: got %b expected %b", i, a, NREQ'(1) << e.idx);
      end
      req = req & ~a;
    end
    req = '0;
    @(negedge hclk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    hresetn = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_dina = '0; req_dinb = '0;
    req_sel = '0; hreadyout = 1'b0; hresp = 1'b0; hrdata = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_error_collision();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
